// File: rtl/mcpu_mem_dtlb.sv
// Data-side TLB: four fully-associative entries backed by a
// two-level page-table walker that reads through the memory arbiter.
module mcpu_mem_dtlb (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        dtlb_re,
  input  logic [19:0] dtlb_addr,
  output logic        dtlb_ready,
  output logic [19:0] dtlb_phys_addr,
  output logic [3:0]  dtlb_flags,
  input  logic        paging_en,
  input  logic [19:0] ptbr,
  input  logic        tlb_flush,
  output logic [31:0] dtlb2arb_addr,
  output logic        dtlb2arb_re,
  input  logic [31:0] arb2dtlb_data,
  input  logic        arb2dtlb_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PDE  = 2'd1;
  localparam logic [1:0] S_PTE  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  ent_v;
  logic [19:0] ent_vpn [4];
  logic [19:0] ent_ppn [4];
  logic [3:0]  ent_flg [4];
  logic [1:0]  fill_ptr;
  logic [19:0] walk_vpn;
  logic        walk_flushed;

  logic [3:0]  match;
  logic        hit;
  logic [19:0] hit_ppn;
  logic [3:0]  hit_flg;
  logic        fill;
  logic        unused_data_bits;

  assign unused_data_bits = ^arb2dtlb_data[11:4];

  // Tag compare and one-hot select of the matching entry
  always_comb begin
    match   = '0;
    hit_ppn = '0;
    hit_flg = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = ent_v[i] && (ent_vpn[i] == dtlb_addr);
      if (match[i]) begin
        hit_ppn = hit_ppn | ent_ppn[i];
        hit_flg = hit_flg | ent_flg[i];
      end
    end
  end

  // A flush in the lookup cycle forces a miss
  assign hit = (|match) && !tlb_flush;

  assign fill = (state == S_PTE) && arb2dtlb_ready
             && arb2dtlb_data[0] && !walk_flushed
             && !tlb_flush;

  // Lookup / walk control and result registers
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state          <= S_IDLE;
      dtlb_ready     <= 1'b1;
      dtlb_phys_addr <= '0;
      dtlb_flags     <= '0;
      dtlb2arb_re    <= 1'b0;
      dtlb2arb_addr  <= '0;
      walk_vpn       <= '0;
      walk_flushed   <= 1'b0;
    end else begin
      if (tlb_flush) walk_flushed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (dtlb_re) begin
            if (!paging_en) begin
              dtlb_ready     <= 1'b1;
              dtlb_phys_addr <= dtlb_addr;
              dtlb_flags     <= 4'hF;
            end else if (hit) begin
              dtlb_ready     <= 1'b1;
              dtlb_phys_addr <= hit_ppn;
              dtlb_flags     <= hit_flg;
            end else begin
              dtlb_ready    <= 1'b0;
              walk_vpn      <= dtlb_addr;
              walk_flushed  <= 1'b0;
              dtlb2arb_re   <= 1'b1;
              dtlb2arb_addr <= {ptbr, dtlb_addr[19:10], 2'b00};
              state         <= S_PDE;
            end
          end
        end
        S_PDE: begin
          if (arb2dtlb_ready) begin
            if (arb2dtlb_data[0]) begin
              dtlb2arb_addr <= {arb2dtlb_data[31:12],
                                walk_vpn[9:0], 2'b00};
              state         <= S_PTE;
            end else begin
              dtlb2arb_re    <= 1'b0;
              dtlb_ready     <= 1'b1;
              dtlb_phys_addr <= '0;
              dtlb_flags     <= '0;
              state          <= S_IDLE;
            end
          end
        end
        S_PTE: begin
          if (arb2dtlb_ready) begin
            dtlb2arb_re    <= 1'b0;
            dtlb_ready     <= 1'b1;
            dtlb_phys_addr <= arb2dtlb_data[31:12];
            dtlb_flags     <= arb2dtlb_data[3:0];
            state          <= S_IDLE;
          end
        end
        default: begin
          dtlb2arb_re <= 1'b0;
          dtlb_ready  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Valid bits and round-robin pointer; flush beats fill
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      ent_v    <= '0;
      fill_ptr <= '0;
    end else if (tlb_flush) begin
      ent_v    <= '0;
    end else if (fill) begin
      ent_v[fill_ptr] <= 1'b1;
      fill_ptr        <= fill_ptr + 2'd1;
    end
  end

  // Entry payload written at the fill pointer
  always_ff @(posedge clkrst_core_clk) begin
    if (fill) begin
      ent_vpn[fill_ptr] <= walk_vpn;
      ent_ppn[fill_ptr] <= arb2dtlb_data[31:12];
      ent_flg[fill_ptr] <= arb2dtlb_data[3:0];
    end
  end

endmodule

// File: tb/tb_mcpu_mem_dtlb.sv
// Randomised bench for mcpu_mem_dtlb against a FIFO-replacement
// TLB model and a sparse page-table memory.
module tb_mcpu_mem_dtlb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dtlb_re = 1'b0;
  logic [19:0] dtlb_addr = '0;
  logic        dtlb_ready;
  logic [19:0] dtlb_phys_addr;
  logic [3:0]  dtlb_flags;
  logic        paging_en = 1'b0;
  logic [19:0] ptbr = '0;
  logic        tlb_flush = 1'b0;
  logic [31:0] dtlb2arb_addr;
  logic        dtlb2arb_re;
  logic [31:0] arb2dtlb_data = '0;
  logic        arb2dtlb_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic [3:0]  flg;
  } tent_t;

  tent_t       tlbq [$];
  logic [31:0] mem [logic [31:0]];

  mcpu_mem_dtlb dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .dtlb_re           (dtlb_re),
    .dtlb_addr         (dtlb_addr),
    .dtlb_ready        (dtlb_ready),
    .dtlb_phys_addr    (dtlb_phys_addr),
    .dtlb_flags        (dtlb_flags),
    .paging_en         (paging_en),
    .ptbr              (ptbr),
    .tlb_flush         (tlb_flush),
    .dtlb2arb_addr     (dtlb2arb_addr),
    .dtlb2arb_re       (dtlb2arb_re),
    .arb2dtlb_data     (arb2dtlb_data),
    .arb2dtlb_ready    (arb2dtlb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] r;
    if (!mem.exists(a)) begin
      r = $urandom();
      mem[a] = r;
    end
    return mem[a];
  endfunction

  // Hold a walk request for a random time, then return one word
  task automatic respond(input logic [31:0] ea, input logic [31:0] d,
                         input bit fl);
    int dly;
    dly = $urandom_range(3, 0);
    if (fl && dly == 0) dly = 1;
    for (int k = 0; k < dly; k++) begin
      dtlb_re   = 1'b1;
      dtlb_addr = 20'($urandom());
      tlb_flush = fl && (k == 0);
      @(negedge clk);
      chk("walk_re_held", {31'd0, dtlb2arb_re}, 32'd1);
      chk("walk_addr_held", dtlb2arb_addr, ea);
      chk("walk_ready_low", {31'd0, dtlb_ready}, 32'd0);
    end
    dtlb_re        = 1'b0;
    tlb_flush      = 1'b0;
    arb2dtlb_ready = 1'b1;
    arb2dtlb_data  = d;
    @(negedge clk);
    arb2dtlb_ready = 1'b0;
  endtask

  task automatic do_lookup(input logic [19:0] vpn, input logic pg,
                           input bit fl_req, input bit fl_pte);
    logic [31:0] ea;
    logic [31:0] pde;
    logic [31:0] pte;
    logic [19:0] eppn;
    logic [3:0]  eflg;
    int idx;
    @(negedge clk);
    dtlb_re   = 1'b1;
    dtlb_addr = vpn;
    paging_en = pg;
    tlb_flush = fl_req;
    @(negedge clk);
    dtlb_re   = 1'b0;
    tlb_flush = 1'b0;
    if (fl_req) tlbq.delete();
    idx = -1;
    foreach (tlbq[i]) if (tlbq[i].vpn == vpn) idx = i;
    if (!pg || idx >= 0) begin
      eppn = pg ? tlbq[idx].ppn : vpn;
      eflg = pg ? tlbq[idx].flg : 4'hF;
      chk("fast_no_walk", {31'd0, dtlb2arb_re}, 32'd0);
    end else begin
      chk("miss_ready", {31'd0, dtlb_ready}, 32'd0);
      ea = {ptbr, vpn[19:10], 2'b00};
      chk("pde_re", {31'd0, dtlb2arb_re}, 32'd1);
      chk("pde_addr", dtlb2arb_addr, ea);
      pde = mem_rd(ea);
      respond(ea, pde, 1'b0);
      if (!pde[0]) begin
        eppn = '0;
        eflg = '0;
      end else begin
        ea = {pde[31:12], vpn[9:0], 2'b00};
        chk("pte_re", {31'd0, dtlb2arb_re}, 32'd1);
        chk("pte_addr", dtlb2arb_addr, ea);
        pte = mem_rd(ea);
        respond(ea, pte, fl_pte);
        if (fl_pte) tlbq.delete();
        eppn = pte[31:12];
        eflg = pte[3:0];
        if (pte[0] && !fl_pte) begin
          if (tlbq.size() == 4) void'(tlbq.pop_front());
          tlbq.push_back({vpn, eppn, eflg});
        end
      end
    end
    chk("done_ready", {31'd0, dtlb_ready}, 32'd1);
    chk("done_ppn", {12'd0, dtlb_phys_addr}, {12'd0, eppn});
    chk("done_flags", {28'd0, dtlb_flags}, {28'd0, eflg});
    arb2dtlb_ready = 1'b1;
    arb2dtlb_data  = $urandom();
    @(negedge clk);
    arb2dtlb_ready = 1'b0;
    chk("hold_ready", {31'd0, dtlb_ready}, 32'd1);
    chk("hold_ppn", {12'd0, dtlb_phys_addr}, {12'd0, eppn});
    chk("hold_flags", {28'd0, dtlb_flags}, {28'd0, eflg});
    chk("idle_no_re", {31'd0, dtlb2arb_re}, 32'd0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    tlb_flush = 1'b1;
    @(negedge clk);
    tlb_flush = 1'b0;
    tlbq.delete();
  endtask

  initial begin
    logic [19:0] v;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, dtlb_ready}, 32'd1);
    chk("rst_ppn", {12'd0, dtlb_phys_addr}, 32'd0);
    chk("rst_flags", {28'd0, dtlb_flags}, 32'd0);
    chk("rst_re", {31'd0, dtlb2arb_re}, 32'd0);
    chk("rst_addr", dtlb2arb_addr, 32'd0);
    rst_n = 1'b1;

    do_lookup(20'h12345, 1'b0, 1'b0, 1'b0);

    ptbr = 20'h00100;
    mem[32'h0010_0004] = 32'h0020_0001;
    mem[32'h0010_0008] = 32'h0030_0001;
    mem[32'h0010_000C] = 32'h0000_0000;
    mem[32'h0020_0004] = 32'h0ABC_D00B;
    do_lookup(20'h00401, 1'b1, 1'b0, 1'b0);
    chk("dir_ppn", {12'd0, dtlb_phys_addr}, 32'h0000_ABCD);
    chk("dir_flags", {28'd0, dtlb_flags}, 32'hB);
    do_lookup(20'h00401, 1'b1, 1'b0, 1'b0);

    do_lookup(20'h00C05, 1'b1, 1'b0, 1'b0);
    do_lookup(20'h00C05, 1'b1, 1'b0, 1'b0);

    do_flush();
    for (int i = 0; i < 5; i++) begin
      v = 20'h00410 + 20'(i);
      a = {20'h00200, v[9:0], 2'b00};
      mem[a] = {20'h50000 + 20'(i), 8'h00, 4'h3};
    end
    for (int i = 0; i < 5; i++)
      do_lookup(20'h00410 + 20'(i), 1'b1, 1'b0, 1'b0);
    do_lookup(20'h00410, 1'b1, 1'b0, 1'b0);
    do_lookup(20'h00414, 1'b1, 1'b0, 1'b0);

    mem[32'h0020_0080] = 32'h7777_7005;
    do_lookup(20'h00420, 1'b1, 1'b0, 1'b1);
    do_lookup(20'h00420, 1'b1, 1'b0, 1'b0);

    do_lookup(20'h00414, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    dtlb_re   = 1'b1;
    dtlb_addr = 20'h00401;
    paging_en = 1'b1;
    @(negedge clk);
    dtlb_re = 1'b0;
    chk("rst_walk_re_pre", {31'd0, dtlb2arb_re}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_walk_re", {31'd0, dtlb2arb_re}, 32'd0);
    chk("rst_walk_ready", {31'd0, dtlb_ready}, 32'd1);
    chk("rst_walk_addr", dtlb2arb_addr, 32'd0);
    tlbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(20'h00414, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      v = {8'd0, 2'($urandom_range(3, 1)),
           10'($urandom_range(15, 0))};
      do_lookup(v, $urandom_range(9, 0) != 0,
                $urandom_range(19, 0) == 0,
                $urandom_range(9, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
